// File: rtl/ivector_arb_pkg.sv
// ivector_arb_pkg: default parameters and sizing helper for the ivector arbiter
package ivector_arb_pkg;
  localparam int NCHAN_DEF  = 10;
  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int METH_W_DEF = 32;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/ivector_arb_if.sv
// ivector_arb_if: say (enqueue) and ind_heard (delivery) handshake bundle
interface ivector_arb_if
  import ivector_arb_pkg::*;
#(
  parameter int METH_W = METH_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              say__ENA;
  logic [METH_W-1:0] say_meth;
  logic [DATA_W-1:0] say_v;
  logic              say__RDY;
  logic              ind_heard__ENA;
  logic [METH_W-1:0] ind_heard_heard_meth;
  logic [DATA_W-1:0] ind_heard_heard_v;
  logic              ind_heard__RDY;
  modport slave (
    input  say__ENA, say_meth, say_v, ind_heard__RDY,
    output say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v
  );
  modport master (
    output say__ENA, say_meth, say_v, ind_heard__RDY,
    input  say__RDY, ind_heard__ENA, ind_heard_heard_meth, ind_heard_heard_v
  );
endinterface

// File: rtl/ivector_chan_fifo.sv
// ivector_chan_fifo: one channel queue with independent pointers and count
module ivector_chan_fifo
  import ivector_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PW = clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push, pop;
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rdata_o = mem_q[rd_q];
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  // pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // control state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage is left unreset; emptiness is tracked by the count alone
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/ivector_arb.sv
// ivector_arb: per-method FIFOs drained by a round-robin arbiter; optional IVECTOR_ARB_STATS_EN adds counters
module ivector_arb
  import ivector_arb_pkg::*;
#(
  parameter int NCHAN  = NCHAN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int METH_W = METH_W_DEF
) (
  input  logic         CLK,
  input  logic         nRST,
  ivector_arb_if.slave bus
`ifdef IVECTOR_ARB_STATS_EN
  ,
  output logic [31:0]  stat_heard_count,
  output logic [0:0]   stat_reject
`endif
);
  localparam int CW = clog2(NCHAN);
  logic [NCHAN-1:0] full, empty;
  logic [DATA_W-1:0] rdata [NCHAN];
  logic [CW-1:0] sel, gnt, rr_q, rr_d;
  logic in_range, push, found;
  assign in_range     = bus.say_meth < METH_W'(NCHAN);
  assign sel          = bus.say_meth[CW-1:0];
  assign bus.say__RDY = in_range && !full[sel];
  assign push         = bus.say__ENA && bus.say__RDY;
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    ivector_chan_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .push_i  (push && sel == CW'(c)),
      .pop_i   (bus.ind_heard__ENA && gnt == CW'(c)),
      .wdata_i (bus.say_v),
      .rdata_o (rdata[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end
  // first non-empty channel at or after rr_q, wrapping modulo NCHAN
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!found && !empty[(int'(rr_q) + i) % NCHAN]) begin
        found = 1'b1;
        gnt   = CW'((int'(rr_q) + i) % NCHAN);
      end
    end
    bus.ind_heard__ENA       = found && bus.ind_heard__RDY;
    bus.ind_heard_heard_meth = bus.ind_heard__ENA ? METH_W'(gnt) : '0;
    bus.ind_heard_heard_v    = bus.ind_heard__ENA ? rdata[gnt] : '0;
    rr_d = !bus.ind_heard__ENA ? rr_q : gnt == CW'(NCHAN - 1) ? '0 : gnt + CW'(1);
  end
  // round-robin pointer
  always_ff @(posedge CLK) begin
    if (!nRST) rr_q <= '0;
    else rr_q <= rr_d;
  end
`ifdef IVECTOR_ARB_STATS_EN
  logic [31:0] cnt_q;
  logic rej_q;
  assign stat_heard_count = cnt_q;
  assign stat_reject      = rej_q;
  // transfer counter and sticky reject flag
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
      rej_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'(bus.ind_heard__ENA);
      rej_q <= rej_q || (bus.say__ENA && !bus.say__RDY);
    end
  end
`endif
endmodule

// File: tb/tb_ivector_arb.sv
// tb_ivector_arb: directed checks of the ivector arbiter (NCHAN=10, DEPTH=4, DATA_W=32)
module tb_ivector_arb;
  logic CLK = 1'b0;
  logic nRST;
  int passed = 0;
  int total = 0;
  ivector_arb_if #(.METH_W(32), .DATA_W(32)) bus ();
`ifdef IVECTOR_ARB_STATS_EN
  logic [31:0] stat_heard_count;
  logic [0:0] stat_reject;
`endif
  ivector_arb #(.NCHAN(10), .DEPTH(4), .DATA_W(32), .METH_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef IVECTOR_ARB_STATS_EN
    ,
    .stat_heard_count (stat_heard_count),
    .stat_reject      (stat_reject)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic put(input int m, input int v);
    bus.say__ENA = 1'b1;
    bus.say_meth = m;
    bus.say_v    = v;
    tick();
    bus.say__ENA = 1'b0;
  endtask
  initial begin
    nRST = 1'b0;
    bus.say__ENA = 1'b0;
    bus.say_meth = 3;
    bus.say_v = '0;
    bus.ind_heard__RDY = 1'b1;
    tick();
    tick();
    @(negedge CLK);
    chk("rst_ena", bus.ind_heard__ENA, 0);
    chk("rst_meth", bus.ind_heard_heard_meth, 0);
    chk("rst_v", bus.ind_heard_heard_v, 0);
    chk("rst_say_rdy", bus.say__RDY, 1);
    tick();
    nRST = 1'b1;
    bus.say__ENA = 1'b1;
    bus.say_meth = 3;
    bus.say_v = 32'h55;
    @(negedge CLK);
    chk("no_bypass", bus.ind_heard__ENA, 0);
    tick();
    bus.say__ENA = 1'b0;
    @(negedge CLK);
    chk("one_ena", bus.ind_heard__ENA, 1);
    chk("one_meth", bus.ind_heard_heard_meth, 3);
    chk("one_v", bus.ind_heard_heard_v, 32'h55);
    tick();
    @(negedge CLK);
    chk("one_after", bus.ind_heard__ENA, 0);
    bus.ind_heard__RDY = 1'b0;
    for (int i = 0; i < 4; i++) put(2, 32'h10 + i);
    bus.say_meth = 2;
    #1;
    chk("full_rdy2", bus.say__RDY, 0);
    bus.say_meth = 5;
    #1;
    chk("other_rdy5", bus.say__RDY, 1);
    chk("hold_ena", bus.ind_heard__ENA, 0);
    bus.ind_heard__RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("drain2_meth", bus.ind_heard_heard_meth, 2);
      chk("drain2_v", bus.ind_heard_heard_v, 32'h10 + i);
      tick();
    end
    @(negedge CLK);
    chk("drain2_empty", bus.ind_heard__ENA, 0);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.ind_heard__RDY = 1'b0;
    put(1, 32'hA1);
    put(4, 32'hA4);
    put(7, 32'hA7);
    bus.ind_heard__RDY = 1'b1;
    @(negedge CLK);
    chk("rr_g1", bus.ind_heard_heard_meth, 1);
    tick();
    @(negedge CLK);
    chk("rr_g4", bus.ind_heard_heard_meth, 4);
    tick();
    @(negedge CLK);
    chk("rr_g7", bus.ind_heard_heard_meth, 7);
    chk("rr_v7", bus.ind_heard_heard_v, 32'hA7);
    tick();
    bus.ind_heard__RDY = 1'b0;
    put(0, 32'hB0);
    put(8, 32'hB8);
    bus.ind_heard__RDY = 1'b1;
    @(negedge CLK);
    chk("rr_g8", bus.ind_heard_heard_meth, 8);
    chk("rr_v8", bus.ind_heard_heard_v, 32'hB8);
    tick();
    @(negedge CLK);
    chk("rr_wrap_g0", bus.ind_heard_heard_meth, 0);
    chk("rr_v0", bus.ind_heard_heard_v, 32'hB0);
    tick();
    @(negedge CLK);
    chk("rr_done", bus.ind_heard__ENA, 0);
    bus.say__ENA = 1'b1;
    bus.say_meth = 10;
    bus.say_v = 32'h77;
    #1;
    chk("oor_rdy", bus.say__RDY, 0);
    @(negedge CLK);
    chk("oor_ena", bus.ind_heard__ENA, 0);
    tick();
    bus.say__ENA = 1'b0;
    @(negedge CLK);
    chk("oor_nodeliv", bus.ind_heard__ENA, 0);
`ifdef IVECTOR_ARB_STATS_EN
    chk("stat_reject_set", stat_reject, 1);
`endif
    bus.ind_heard__RDY = 1'b0;
    put(6, 32'h61);
    bus.ind_heard__RDY = 1'b1;
    bus.say__ENA = 1'b1;
    bus.say_meth = 6;
    bus.say_v = 32'hAA;
    @(negedge CLK);
    chk("same_say_rdy", bus.say__RDY, 1);
    chk("same_meth", bus.ind_heard_heard_meth, 6);
    chk("same_v_old", bus.ind_heard_heard_v, 32'h61);
    tick();
    bus.say__ENA = 1'b0;
    @(negedge CLK);
    chk("same_ena_new", bus.ind_heard__ENA, 1);
    chk("same_v_new", bus.ind_heard_heard_v, 32'hAA);
    tick();
    @(negedge CLK);
    chk("same_count1", bus.ind_heard__ENA, 0);
    bus.ind_heard__RDY = 1'b0;
    for (int i = 0; i < 4; i++) put(9, 32'h90 + i);
    bus.ind_heard__RDY = 1'b1;
    bus.say__ENA = 1'b1;
    bus.say_meth = 9;
    bus.say_v = 32'hEE;
    @(negedge CLK);
    chk("full_deq_rdy", bus.say__RDY, 0);
    chk("full_deq_v", bus.ind_heard_heard_v, 32'h90);
    tick();
    bus.say__ENA = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk("full_drain_v", bus.ind_heard_heard_v, 32'h90 + i);
      tick();
    end
    @(negedge CLK);
    chk("full_reject_kept_out", bus.ind_heard__ENA, 0);
    bus.ind_heard__RDY = 1'b0;
    put(0, 32'hC0);
    put(1, 32'hC1);
    put(2, 32'hC2);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    bus.ind_heard__RDY = 1'b1;
    @(negedge CLK);
    chk("midrst_ena", bus.ind_heard__ENA, 0);
    for (int m = 0; m < 10; m++) begin
      bus.say_meth = m;
      #0.1;
      chk("midrst_say_rdy", bus.say__RDY, 1);
    end
`ifdef IVECTOR_ARB_STATS_EN
    chk("midrst_count", stat_heard_count, 0);
    chk("midrst_reject", stat_reject, 0);
`endif
    tick();
    tick();
    @(negedge CLK);
    chk("midrst_no_deliv", bus.ind_heard__ENA, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
